// File: rtl/turbo_pkg.sv
// Shared turbo-decoder constants: default LLR width, frame length and the
// interleaver permutation tables used by the frame buffers.
package turbo_pkg;

  localparam int unsigned LLR_W     = 6;
  localparam int unsigned FRAME_LEN = 5;
  localparam int unsigned IDX_W     = $clog2(FRAME_LEN);

  typedef logic [IDX_W-1:0] idx_t;

  // out[i] = in[PI[i]]; PI_INV undoes it
  localparam idx_t PI [FRAME_LEN] = '{idx_t'(3), idx_t'(1), idx_t'(2), idx_t'(4), idx_t'(0)};
  localparam idx_t PI_INV [FRAME_LEN] = '{idx_t'(4), idx_t'(1), idx_t'(2), idx_t'(0), idx_t'(3)};

  function automatic idx_t perm_addr(input idx_t cnt, input logic inverse);
    return inverse ? PI_INV[cnt] : PI[cnt];
  endfunction

endpackage

// File: rtl/llr_bank.sv
// One frame of LLR storage: synchronous write, asynchronous read, no reset.
module llr_bank #(
  parameter int unsigned LLR_W = turbo_pkg::LLR_W,
  parameter int unsigned DEPTH = turbo_pkg::FRAME_LEN,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [LLR_W-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [LLR_W-1:0] rdata
);

  logic [LLR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/llr_interleave_buffer.sv
// Double-buffered LLR frame store: frames arrive in natural order and leave
// in interleaved (MODE=0) or de-interleaved (MODE=1) order.
module llr_interleave_buffer #(
  parameter int unsigned LLR_W     = turbo_pkg::LLR_W,
  parameter int unsigned FRAME_LEN = turbo_pkg::FRAME_LEN,
  parameter bit          MODE      = 1'b0
) (
  input  logic             clk_p_i,
  input  logic             reset_p_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [LLR_W-1:0] in_llr_i,
  input  logic             in_last_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [LLR_W-1:0] out_llr_o,
  output logic             out_last_o,
  output logic             frame_err_o
);

  localparam int unsigned CNT_W = $clog2(FRAME_LEN);
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t LAST_IDX = CNT_W'(FRAME_LEN - 1);

  logic       wr_sel, wr_sel_nxt;
  logic       rd_sel, rd_sel_nxt;
  cnt_t       wr_cnt, wr_cnt_nxt;
  cnt_t       rd_cnt, rd_cnt_nxt;
  logic [1:0] full, full_nxt;
  logic       err_nxt;

  logic wr_fire;
  logic rd_fire;
  cnt_t rd_addr;
  logic [LLR_W-1:0] bank_rdata [2];

  assign in_ready_o  = ~full[wr_sel] & ~reset_p_i;
  assign wr_fire     = in_valid_i & in_ready_o;
  assign out_valid_o = full[rd_sel];
  assign rd_fire     = out_valid_o & out_ready_i;
  assign rd_addr     = CNT_W'(turbo_pkg::perm_addr(turbo_pkg::idx_t'(rd_cnt), MODE));
  assign out_llr_o   = out_valid_o ? bank_rdata[rd_sel] : '0;
  assign out_last_o  = out_valid_o & (rd_cnt == LAST_IDX);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    llr_bank #(
      .LLR_W (LLR_W),
      .DEPTH (FRAME_LEN)
    ) u_bank (
      .clk   (clk_p_i),
      .we    (wr_fire & (wr_sel == 1'(b))),
      .waddr (wr_cnt),
      .wdata (in_llr_i),
      .raddr (rd_addr),
      .rdata (bank_rdata[b])
    );
  end

  // Write and read sides touch different banks, so both updates can land together
  always_comb begin
    wr_sel_nxt = wr_sel;
    rd_sel_nxt = rd_sel;
    wr_cnt_nxt = wr_cnt;
    rd_cnt_nxt = rd_cnt;
    full_nxt   = full;
    err_nxt    = 1'b0;

    if (wr_fire) begin
      if (wr_cnt == LAST_IDX) begin
        full_nxt[wr_sel] = 1'b1;
        wr_sel_nxt       = ~wr_sel;
        wr_cnt_nxt       = '0;
        err_nxt          = ~in_last_i;
      end else if (in_last_i) begin
        wr_cnt_nxt = '0;
        err_nxt    = 1'b1;
      end else begin
        wr_cnt_nxt = wr_cnt + 1'b1;
      end
    end

    if (rd_fire) begin
      if (rd_cnt == LAST_IDX) begin
        full_nxt[rd_sel] = 1'b0;
        rd_sel_nxt       = ~rd_sel;
        rd_cnt_nxt       = '0;
      end else begin
        rd_cnt_nxt = rd_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_p_i or posedge reset_p_i) begin
    if (reset_p_i) begin
      wr_sel      <= 1'b0;
      rd_sel      <= 1'b0;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      full        <= '0;
      frame_err_o <= 1'b0;
    end else begin
      wr_sel      <= wr_sel_nxt;
      rd_sel      <= rd_sel_nxt;
      wr_cnt      <= wr_cnt_nxt;
      rd_cnt      <= rd_cnt_nxt;
      full        <= full_nxt;
      frame_err_o <= err_nxt;
    end
  end

endmodule

// File: tb/tb_llr_interleave_buffer.sv
// Bench for llr_interleave_buffer: MODE=0 and MODE=1 instances share stimulus
// and are compared every cycle against a frame-queue reference model.
module tb_llr_interleave_buffer;

  localparam int FL = 5;
  localparam int W  = 6;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_llr;
  logic         in_last;
  logic         out_ready;

  logic         in_ready0, out_valid0, out_last0, err0;
  logic [W-1:0] out_llr0;
  logic         in_ready1, out_valid1, out_last1, err1;
  logic [W-1:0] out_llr1;

  always #5 clk = ~clk;

  llr_interleave_buffer #(.LLR_W(W), .FRAME_LEN(FL), .MODE(1'b0)) dut0 (
    .clk_p_i(clk), .reset_p_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready0),
    .in_llr_i(in_llr), .in_last_i(in_last), .out_valid_o(out_valid0),
    .out_ready_i(out_ready), .out_llr_o(out_llr0), .out_last_o(out_last0),
    .frame_err_o(err0)
  );

  llr_interleave_buffer #(.LLR_W(W), .FRAME_LEN(FL), .MODE(1'b1)) dut1 (
    .clk_p_i(clk), .reset_p_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready1),
    .in_llr_i(in_llr), .in_last_i(in_last), .out_valid_o(out_valid1),
    .out_ready_i(out_ready), .out_llr_o(out_llr1), .out_last_o(out_last1),
    .frame_err_o(err1)
  );

  int pi_t     [FL] = '{3, 1, 2, 4, 0};
  int pi_inv_t [FL] = '{4, 1, 2, 0, 3};

  int errors = 0;
  int checks = 0;

  // reference model: complete frames in arrival order plus the open partial frame
  logic [W-1:0] sq[$];
  logic [W-1:0] pq[$];
  int           rd_idx;
  bit           err_exp;
  int           dut_err_cnt = 0;

  // stimulus and captured outputs
  logic [W-1:0] stim_llr[$];
  bit           stim_last[$];
  logic [W-1:0] cap0[$];
  logic [W-1:0] cap1[$];
  int           ready_mode = 0;
  int           gap_pct = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got=%0d exp=%0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    sq.delete();
    pq.delete();
    rd_idx  = 0;
    err_exp = 1'b0;
  endtask

  function automatic logic [W-1:0] exp_llr(input bit inverse);
    if (sq.size() < FL) return '0;
    return inverse ? sq[pi_inv_t[rd_idx]] : sq[pi_t[rd_idx]];
  endfunction

  task automatic drive_inputs();
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
    if (stim_llr.size() > 0 && int'($urandom_range(0, 99)) >= gap_pct) begin
      in_valid = 1'b1;
      in_llr   = stim_llr[0];
      in_last  = stim_last[0];
    end else begin
      in_valid = 1'b0;
      in_llr   = W'($urandom);
      in_last  = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic step();
    bit exp_rdy, exp_vld, exp_last, in_fire, out_fire;
    @(negedge clk);
    exp_rdy  = !rst && (sq.size() < 2 * FL);
    exp_vld  = !rst && (sq.size() >= FL);
    exp_last = exp_vld && (rd_idx == FL - 1);
    check_eq("in_ready0", 32'(in_ready0), 32'(exp_rdy));
    check_eq("in_ready1", 32'(in_ready1), 32'(exp_rdy));
    check_eq("out_valid0", 32'(out_valid0), 32'(exp_vld));
    check_eq("out_valid1", 32'(out_valid1), 32'(exp_vld));
    check_eq("out_llr0", 32'(out_llr0), 32'(exp_llr(1'b0)));
    check_eq("out_llr1", 32'(out_llr1), 32'(exp_llr(1'b1)));
    check_eq("out_last0", 32'(out_last0), 32'(exp_last));
    check_eq("out_last1", 32'(out_last1), 32'(exp_last));
    check_eq("frame_err0", 32'(err0), 32'(err_exp));
    check_eq("frame_err1", 32'(err1), 32'(err_exp));
    if (err0) dut_err_cnt++;
    in_fire  = in_valid && exp_rdy;
    out_fire = exp_vld && out_ready;
    if (out_fire) begin
      cap0.push_back(out_llr0);
      cap1.push_back(out_llr1);
    end
    @(posedge clk);
    err_exp = 1'b0;
    if (rst) begin
      model_reset();
    end else begin
      if (out_fire) begin
        rd_idx++;
        if (rd_idx == FL) begin
          repeat (FL) void'(sq.pop_front());
          rd_idx = 0;
        end
      end
      if (in_fire) begin
        pq.push_back(in_llr);
        if (pq.size() == FL) begin
          foreach (pq[i]) sq.push_back(pq[i]);
          pq.delete();
          err_exp = !in_last;
        end else if (in_last) begin
          pq.delete();
          err_exp = 1'b1;
        end
        void'(stim_llr.pop_front());
        void'(stim_last.pop_front());
      end
    end
    #1;
    drive_inputs();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic push_sample(input logic [W-1:0] v, input bit last);
    stim_llr.push_back(v);
    stim_last.push_back(last);
  endtask

  task automatic push_random_frame(input int last_at, input bit last_val);
    for (int i = 0; i <= last_at; i++)
      push_sample(W'($urandom), (i == last_at) ? last_val : 1'b0);
  endtask

  task automatic clear_caps();
    cap0.delete();
    cap1.delete();
  endtask

  initial begin
    int base_err;
    int exp0 [FL];
    int exp1 [FL];
    logic [W-1:0] fwd [$];

    rst = 1'b1; in_valid = 1'b0; in_llr = '0; in_last = 1'b0; out_ready = 1'b1;
    model_reset();
    #2;
    check_eq("rst_in_ready", 32'(in_ready0), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid0), 32'd0);
    check_eq("rst_out_llr", 32'(out_llr0), 32'd0);
    check_eq("rst_out_last", 32'(out_last0), 32'd0);
    check_eq("rst_frame_err", 32'(err0), 32'd0);
    run(2);
    rst = 1'b0;
    run(1);

    // natural frame 10..14 through both modes
    clear_caps();
    for (int i = 0; i < FL; i++) push_sample(W'(10 + i), i == FL - 1);
    drive_inputs();
    run(14);
    exp0 = '{13, 11, 12, 14, 10};
    exp1 = '{14, 11, 12, 10, 13};
    check_eq("t1_count", 32'(cap0.size()), 32'(FL));
    for (int i = 0; i < FL; i++) begin
      check_eq("t1_mode0", 32'(cap0[i]), 32'(exp0[i]));
      check_eq("t2_mode1", 32'(cap1[i]), 32'(exp1[i]));
    end

    // interleaved frame through the de-interleaver returns natural order
    fwd = cap0;
    clear_caps();
    for (int i = 0; i < FL; i++) push_sample(fwd[i], i == FL - 1);
    drive_inputs();
    run(14);
    for (int i = 0; i < FL; i++) check_eq("t2_roundtrip", 32'(cap1[i]), 32'(10 + i));

    // three frames against a stalled consumer
    clear_caps();
    ready_mode = 1;
    for (int f = 0; f < 3; f++) push_random_frame(FL - 1, 1'b1);
    drive_inputs();
    run(12);
    check_eq("t3_stall_ready", 32'(in_ready0), 32'd0);
    check_eq("t3_stall_pending", 32'(stim_llr.size()), 32'(FL));
    ready_mode = 0;
    drive_inputs();
    run(25);
    check_eq("t3_count", 32'(cap0.size()), 32'(3 * FL));
    check_eq("t3_drained", 32'(stim_llr.size()), 32'd0);

    // early last drops frame A, frame B emitted
    clear_caps();
    base_err = dut_err_cnt;
    for (int i = 0; i < 3; i++) push_sample(W'(20 + i), i == 2);
    for (int i = 0; i < FL; i++) push_sample(W'(1 + i), i == FL - 1);
    drive_inputs();
    run(18);
    exp0 = '{4, 2, 3, 5, 1};
    check_eq("t4_err_pulses", 32'(dut_err_cnt - base_err), 32'd1);
    check_eq("t4_count", 32'(cap0.size()), 32'(FL));
    for (int i = 0; i < FL; i++) check_eq("t4_frame_b", 32'(cap0[i]), 32'(exp0[i]));

    // full frame with last missing still emitted
    clear_caps();
    base_err = dut_err_cnt;
    push_random_frame(FL - 1, 1'b0);
    drive_inputs();
    run(14);
    check_eq("t5_err_pulses", 32'(dut_err_cnt - base_err), 32'd1);
    check_eq("t5_count", 32'(cap0.size()), 32'(FL));

    // reset in the middle of an output frame
    push_random_frame(FL - 1, 1'b1);
    drive_inputs();
    run(8);
    rst = 1'b1;
    #1;
    check_eq("t6_rst_valid", 32'(out_valid0), 32'd0);
    check_eq("t6_rst_llr", 32'(out_llr0), 32'd0);
    check_eq("t6_rst_last", 32'(out_last0), 32'd0);
    check_eq("t6_rst_ready", 32'(in_ready0), 32'd0);
    model_reset();
    stim_llr.delete();
    stim_last.delete();
    drive_inputs();
    step();
    rst = 1'b0;
    step();
    check_eq("t6_post_ready", 32'(in_ready0), 32'd1);
    check_eq("t6_post_valid", 32'(out_valid0), 32'd0);
    clear_caps();
    push_random_frame(FL - 1, 1'b1);
    drive_inputs();
    run(14);
    check_eq("t6_count", 32'(cap0.size()), 32'(FL));

    // random traffic with framing faults and backpressure
    ready_mode = 2;
    gap_pct    = 30;
    for (int f = 0; f < 24; f++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0)      push_random_frame(int'($urandom_range(0, FL - 2)), 1'b1);
      else if (r == 1) push_random_frame(FL - 1, 1'b0);
      else             push_random_frame(FL - 1, 1'b1);
    end
    drive_inputs();
    run(400);
    ready_mode = 0;
    gap_pct    = 0;
    drive_inputs();
    run(30);
    check_eq("t7_drained", 32'(stim_llr.size()), 32'd0);
    check_eq("t7_empty", 32'(out_valid0), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
